// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared pipeline stage widths and the stage occupancy state type.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 178;
    localparam int EX_MEM_W = 155;
    localparam int MEM_WB_W = 117;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sat_counter
// Purpose  : Saturating up-counter for performance events; clears on reset.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with flush and stall counter.
//            PIPE_STAGE_SKID_EN selects the two-entry skid build with a
//            registered in_ready; otherwise a single register is used.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}},
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_out_valid;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             w_load_skid;
    logic             w_main_from_skid;

    // Registered ready, masked during reset so the reset cycle refuses input.
    assign in_ready = r_in_ready & ~reset;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = TWO;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_fire) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_main     <= RESET_DATA;
            r_skid     <= RESET_DATA;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
            if (w_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_load_main) begin
                r_main <= in_data;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end
`else
    assign in_ready = ~reset & (out_ready | ~w_out_valid);

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    // in_fire in ONE implies out_fire: replace in place.
                    if (w_in_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_main  <= RESET_DATA;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= in_data;
            end
        end
    end
`endif

    assign out_valid = w_out_valid;
    assign out_data  = r_main;

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench; follows PIPE_STAGE_SKID_EN build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready3;
    logic        out_valid3;
    logic [63:0] out_data3;
    logic [2:0]  stall_cnt3;

    int n_total;
    int n_bad;
    int exp_stall;

    pipe_stage_reg #(
        .WIDTH      (64),
        .RESET_DATA (64'hDEAD_BEEF),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    // Narrow-counter copy driven by the same stimulus for the saturation case.
    pipe_stage_reg #(
        .WIDTH      (64),
        .RESET_DATA (64'hDEAD_BEEF),
        .CNT_W      (3)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_data  (out_data3),
        .stall_cnt (stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        n_total++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready_during got=%0b exp=0", in_ready);
        end
        reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        n_total++;
        if (out_data !== 64'hDEAD_BEEF) begin
            n_bad++; $display("FAIL reset_out_data got=%0h exp=deadbeef", out_data);
        end
        n_total++;
        if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0) begin
            n_bad++; $display("FAIL reset_stall_cnt got=%0d/%0d exp=0/0", stall_cnt, stall_cnt3);
        end
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready_after got=%0b exp=1", in_ready);
        end
        exp_stall = 0;
    endtask

    task automatic test_stream();
        logic [63:0] exp_d;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'd1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_d = 64'(k);
            n_total++;
            if (out_valid !== 1'b1 || out_data !== exp_d || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_%0d got v=%0b d=%0h r=%0b exp v=1 d=%0h r=1",
                         k, out_valid, out_data, in_ready, exp_d);
            end
            in_data = 64'(k + 1);
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL stream_drain got=%0b exp=0", out_valid);
        end
        n_total++;
        if (stall_cnt !== 16'd0) begin
            n_bad++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt);
        end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
        tick();
        in_data = 64'd6;
        tick();
        exp_stall += 1;
        n_total++;
        if (in_ready !== 1'b0 || out_data !== 64'd5) begin
            n_bad++; $display("FAIL bp_skid_full got r=%0b d=%0h exp r=0 d=5", in_ready, out_data);
        end
        in_data = 64'd7;
        tick();
        tick();
        exp_stall += 2;
        n_total++;
        if (in_ready !== 1'b0 || out_data !== 64'd5 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold got r=%0b v=%0b d=%0h exp r=0 v=1 d=5", in_ready, out_valid, out_data);
        end
        n_total++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_bad++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
        end
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_data !== 64'd6 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got d=%0h r=%0b exp d=6 r=1", out_data, in_ready);
        end
        tick();
        n_total++;
        if (out_data !== 64'd7 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_third got d=%0h v=%0b exp d=7 v=1", out_data, out_valid);
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL bp_drain got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, stall_cnt, exp_stall);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
        tick();
        in_data = 64'd10;
        tick();
        exp_stall += 1;
        flush = 1'b1; in_data = 64'd9;
        tick();
        exp_stall += 1;
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd8) begin
            n_bad++;
            $display("FAIL flush_two got v=%0b r=%0b d=%0h exp v=0 r=1 d=8", out_valid, in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL flush_no_emerge got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, stall_cnt, exp_stall);
        end
    endtask
`else
    task automatic test_comb_ready();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
        tick();
        n_total++;
        if (in_ready !== 1'b0 || out_data !== 64'd5) begin
            n_bad++; $display("FAIL comb_full got r=%0b d=%0h exp r=0 d=5", in_ready, out_data);
        end
        in_data = 64'd6;
        tick();
        exp_stall += 1;
        n_total++;
        if (out_data !== 64'd5 || stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL comb_hold got d=%0h cnt=%0d exp d=5 cnt=%0d", out_data, stall_cnt, exp_stall);
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL comb_passthru got=%0b exp=1", in_ready);
        end
        tick();
        n_total++;
        if (out_data !== 64'd6 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL comb_replace got d=%0h v=%0b exp d=6 v=1", out_data, out_valid);
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL comb_drain got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, stall_cnt, exp_stall);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
        tick();
        out_ready = 1'b1; flush = 1'b1; in_data = 64'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd8) begin
            n_bad++;
            $display("FAIL flush_one got v=%0b r=%0b d=%0h exp v=0 r=1 d=8", out_valid, in_ready, out_data);
        end
        tick();
        tick();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL flush_no_emerge got v=%0b cnt=%0d exp v=0 cnt=%0d", out_valid, stall_cnt, exp_stall);
        end
    endtask
`endif

    task automatic test_saturate();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        exp_stall += 10;
        n_total++;
        if (stall_cnt3 !== 3'd7) begin
            n_bad++; $display("FAIL sat_cnt3 got=%0d exp=7", stall_cnt3);
        end
        n_total++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_bad++; $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, exp_stall);
        end
        flush = 1'b1;
        tick();
        exp_stall += 1;
        flush = 1'b0;
        n_total++;
        if (stall_cnt3 !== 3'd7 || stall_cnt !== 16'(exp_stall) || out_valid3 !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_after_flush got c3=%0d c16=%0d v=%0b exp c3=7 c16=%0d v=0",
                     stall_cnt3, stall_cnt, out_valid3, exp_stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (stall_cnt3 !== 3'd0 || stall_cnt !== 16'd0 || out_data3 !== 64'hDEAD_BEEF
            || in_ready3 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_reset got c3=%0d c16=%0d d=%0h r=%0b exp 0 0 deadbeef 1",
                     stall_cnt3, stall_cnt, out_data3, in_ready3);
        end
        exp_stall = 0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        exp_stall = 0;
        test_reset();
        test_stream();
`ifdef PIPE_STAGE_SKID_EN
        test_backpressure();
`else
        test_comb_ready();
`endif
        test_flush();
        test_saturate();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-width stage latches between IF/ID, ID/EX, EX/MEM and MEM/WB. It adds a valid/ready handshake, synchronous flush for branch/exception squash, synchronous reset and a saturating back-pressure counter. It sits between any two pipeline stages and replaces a hard-wired latch of arbitrary width.

## Interface
- `WIDTH`, 64: payload width in bits; must be ≥1.
- `RESET_DATA`, `{WIDTH{1'b0}}`: value loaded into the payload registers on reset.
- `CNT_W`, 16: width of the stall counter; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage can accept a payload.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage holds a payload for downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  payload presented downstream.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Handshake signals:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
- Priority each cycle is reset, then flush, then normal transfer.
- Reset:
  - state EMPTY, `out_valid`=0, payload registers = `RESET_DATA`, `stall_cnt`=0.
  - `in_ready`=0 in the reset cycle and 1 from the next cycle.
- Flush:
  - Next state is EMPTY and `out_valid`=0 next cycle. Payload registers hold their values.
  - An in_fire coincident with flush is discarded.
  - `stall_cnt` is not affected.
- States (skid build), with main = output register and skid = overflow register:
  - EMPTY: on in_fire, main ← `in_data` and go to ONE.
  - ONE, in_fire and out_fire: main ← `in_data`, stay in ONE.
  - ONE, in_fire only: skid ← `in_data`, go to TWO.
  - ONE, out_fire only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: `in_ready`=0. On out_fire, main ← skid and go to ONE; otherwise hold.
- Outputs:
  - `out_valid` = (state≠EMPTY).
  - `out_data` = main.
  - `in_ready` = (state≠TWO), driven from a register so it is not combinationally dependent on `out_ready`.
- Ordering: payloads leave in acceptance order. None are duplicated or dropped except by flush.
- `stall_cnt` increments by one on every cycle with `out_valid & ~out_ready`. It saturates at all-ones and clears only on reset.

## Timing
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (cycle N+1).
- Throughput: one payload per cycle while `out_ready`=1.
- `out_data` is stable while `out_valid & ~out_ready`.
- `in_data` is sampled only on in_fire.
- Simultaneous in_fire and out_fire in ONE gives no bubble and no skid use.
- `in_ready` deasserts one cycle after the skid fills. It reasserts the cycle after the first out_fire from TWO.
- Reset or flush asserted mid-transfer has the effect described above, applied at that edge.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Two-entry skid implementation as above.
  - Registered `in_ready`; full throughput under back-pressure.
- Not defined:
  - Single register only; states are EMPTY and ONE, TWO is unreachable.
  - `in_ready` = `out_ready | ~out_valid` (combinational pass-through).
  - On in_fire, main ← `in_data`. Latency, flush, reset and `stall_cnt` behaviour are unchanged.

## Structure
- Shared package `pipeline_pkg`:
  - stage widths as constants: `IF_ID_W`=64, `ID_EX_W`=178, `EX_MEM_W`=155, `MEM_WB_W`=117.
  - the state enum `stage_state_t` {EMPTY, ONE, TWO}.
- Sub-module `pipe_sat_counter` (parameter `CNT_W`; ports `clk`, `reset`, `inc`, `count`) implements `stall_cnt`. It is reusable by other performance counters.

## Test plan
- Reset with `RESET_DATA`=64'hDEAD_BEEF → `out_valid`=0, `out_data`=64'hDEAD_BEEF, `stall_cnt`=0, `in_ready`=1 the cycle after reset.
- Streaming with `out_ready`=1, inputs 1,2,3,4 on consecutive cycles → outputs 1,2,3,4 one cycle later with no bubbles, and `stall_cnt` stays 0.
- Back-pressure (skid build): hold `out_ready`=0 and offer 5,6,7 → only 5 and 6 are accepted and `in_ready`=0. Release `out_ready` → outputs 5,6 in order, then 7 is accepted, and `stall_cnt` equals the number of stalled cycles.
- Flush while in TWO, with an in_valid of 9 in the same cycle → `out_valid`=0 next cycle, 9 never emerges, and `in_ready`=1.
- `CNT_W`=3 with 10 stall cycles → `stall_cnt` saturates at 7. A following flush leaves it at 7; reset clears it to 0.
- Non-skid build: `out_ready`=0 with the stage full → `in_ready`=0 in the same cycle. Raise `out_ready` → `in_ready`=1 combinationally and the payload is replaced at the edge.
